// File: rtl/fib_pkg.sv
// fib_pkg
// Shared definitions for the Fibonacci pair serializer slice.
//   FIB_W      : default data word width used by the serializer and its FIFO
//   fib_pair_t : one pair of consecutive Fibonacci numbers at the default width,
//                num is the older value and num2 the newer one
package fib_pkg;

  localparam int FIB_W = 16;

  typedef struct packed {
    logic [FIB_W-1:0] num;
    logic [FIB_W-1:0] num2;
  } fib_pair_t;

endpackage

// File: rtl/fib_pair_fifo.sv
// fib_pair_fifo
// DEPTH-entry FIFO of (num, num2) word pairs with level tracking.
// DEPTH must be a power of two (>= 2) so the pointers wrap by natural overflow.
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   push, wr_num(2)   : write request and the pair to store (ignored when full)
//   pop               : read request (ignored when empty)
//   rd_num, rd_num2   : pair at the head of the FIFO
//   full, empty       : occupancy flags
//   level             : number of stored pairs, 0..DEPTH
module fib_pair_fifo
  import fib_pkg::*;
#(
  parameter int W     = FIB_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wr_num,
  input  logic [W-1:0]             wr_num2,
  input  logic                     pop,
  output logic [W-1:0]             rd_num,
  output logic [W-1:0]             rd_num2,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [2*W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q,  level_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign level   = level_q;

  assign {rd_num, rd_num2} = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    // A simultaneous push and pop cancels out in the level count.
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is deliberately not reset; the level/pointers decide what is live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {wr_num, wr_num2};
  end

endmodule

// File: rtl/fib_pair_serializer.sv
// fib_pair_serializer
// Accepts pairs of consecutive Fibonacci numbers, buffers them in a FIFO and
// emits them as a single-word stream: num of the head pair, then its num2.
// Optional feature macro: FIB_PAIR_SERIALIZER_CHECK_EN enables a sticky
// recurrence checker on accepted pairs; without it err is tied low.
// Ports:
//   clk, rst                    : clock and synchronous active-high reset
//   in_valid/in_ready           : input pair handshake
//   in_num, in_num2             : older and newer number of the input pair
//   out_valid/out_ready/out_num : serialized word stream handshake and data
//   level                       : number of pairs currently buffered
//   err                         : sticky recurrence-error flag
module fib_pair_serializer
  import fib_pkg::*;
#(
  parameter int W     = FIB_W,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_num,
  input  logic [W-1:0]           in_num2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_num,
  output logic [$clog2(DEPTH):0] level,
  output logic                   err
);

  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  logic         fire;
  logic [W-1:0] head_num;
  logic [W-1:0] head_num2;
  logic         phase_q, phase_d;

  // in_ready depends only on the registered level, so a pop in the same
  // cycle never lets a push into a full buffer.
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign fire      = out_valid && out_ready;
  // The pair leaves the buffer only once its second word has been taken.
  assign pop       = fire && phase_q;
  assign out_num   = phase_q ? head_num2 : head_num;

  fib_pair_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_num  (in_num),
    .wr_num2 (in_num2),
    .pop     (pop),
    .rd_num  (head_num),
    .rd_num2 (head_num2),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_comb begin
    phase_d = phase_q;
    if (fire) phase_d = !phase_q;
  end

  always_ff @(posedge clk) begin
    if (rst) phase_q <= 1'b0;
    else     phase_q <= phase_d;
  end

`ifdef FIB_PAIR_SERIALIZER_CHECK_EN
  logic         have_prev_q, have_prev_d;
  logic [W-1:0] prev_a_q, prev_a_d;
  logic [W-1:0] prev_b_q, prev_b_d;
  logic [W-1:0] exp_c;
  logic [W-1:0] exp_d;
  logic         err_q, err_d;

  // Sums are truncated to W bits, so the recurrence is checked modulo 2^W.
  assign exp_c = W'(prev_a_q + prev_b_q);
  assign exp_d = W'(prev_b_q + in_num);

  // The first pair after reset has no predecessor and is never flagged.
  always_comb begin
    have_prev_d = have_prev_q;
    prev_a_d    = prev_a_q;
    prev_b_d    = prev_b_q;
    err_d       = err_q;
    if (push) begin
      have_prev_d = 1'b1;
      prev_a_d    = in_num;
      prev_b_d    = in_num2;
      if (have_prev_q && ((in_num != exp_c) || (in_num2 != exp_d))) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      have_prev_q <= 1'b0;
      prev_a_q    <= '0;
      prev_b_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      have_prev_q <= have_prev_d;
      prev_a_q    <= prev_a_d;
      prev_b_q    <= prev_b_d;
      err_q       <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fib_pair_serializer.sv
// tb_fib_pair_serializer
// Scoreboard bench for fib_pair_serializer: stimulus tasks queue the expected
// words, an independent monitor pops and compares on every output transfer.
module tb_fib_pair_serializer;
  import fib_pkg::*;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_num = '0;
  logic [W-1:0]     in_num2 = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     out_num;
  logic [LVL_W-1:0] level;
  logic             err;

  int testsRun  = 0;
  int testsFail = 0;
  int cycle     = 0;

  logic [W-1:0] sb[$];
  int           popCycles[$];

`ifdef FIB_PAIR_SERIALIZER_CHECK_EN
  localparam logic CHECK_ERR = 1'b1;
`else
  localparam logic CHECK_ERR = 1'b0;
`endif

  fib_pair_serializer #(
    .W     (W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_num    (in_num),
    .in_num2   (in_num2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_num   (out_num),
    .level     (level),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic reportTimeout(input string name);
    testsRun++;
    testsFail++;
    $display("[TB] FAIL %s: timed out, got no progress, expected completion", name);
  endtask

  // Offer one pair, wait (bounded) until it is accepted, then queue its words.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    int waitCount = 0;
    in_num   = a;
    in_num2  = b;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waitCount++;
      if (waitCount > 50) begin
        reportTimeout("push_accept");
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sb.push_back(a);
    sb.push_back(b);
  endtask

  task automatic applyReset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    sb.delete();
    popCycles.delete();
  endtask

  task automatic waitDrain(input int bound);
    int n = 0;
    while (sb.size() != 0 || out_valid) begin
      @(posedge clk);
      #1;
      n++;
      if (n > bound) begin
        reportTimeout("drain");
        return;
      end
    end
  endtask

  // Monitor: every accepted output word is compared against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          testsRun++;
          testsFail++;
          $display("[TB] FAIL out_unexpected: got word %0d, expected no output", out_num);
        end else begin
          checkOutput("out_num", {16'd0, out_num}, {16'd0, sb.pop_front()});
        end
        popCycles.push_back(cycle);
      end
    end
  end

  initial begin
    fib_pair_t streamVec [3];
    fib_pair_t bpVec [4];
    streamVec = '{'{16'd1, 16'd1}, '{16'd2, 16'd3}, '{16'd5, 16'd8}};
    bpVec     = '{'{16'd1, 16'd1}, '{16'd2, 16'd3}, '{16'd5, 16'd8}, '{16'd13, 16'd21}};

    // Reset state
    applyReset(2);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_in_ready",  {31'd0, in_ready},  32'd1);
    checkOutput("reset_level",     {29'd0, level},     32'd0);
    checkOutput("reset_err",       {31'd0, err},       32'd0);
    rst = 1'b0;

    // Streaming at full rate
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) applyStimulus(streamVec[i].num, streamVec[i].num2);
    waitDrain(20);
    checkOutput("stream_word_count", popCycles.size(), 32'd6);
    if (popCycles.size() == 6)
      checkOutput("stream_back_to_back", popCycles[5] - popCycles[0], 32'd5);
    checkOutput("stream_err", {31'd0, err}, 32'd0);

    // Backpressure: fill the buffer, verify hold, then release
    applyReset(2);
    rst = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(bpVec[i].num, bpVec[i].num2);
    checkOutput("bp_level_full", {29'd0, level},    32'd4);
    checkOutput("bp_in_ready",   {31'd0, in_ready}, 32'd0);
    checkOutput("bp_out_valid",  {31'd0, out_valid}, 32'd1);
    checkOutput("bp_out_held",   {16'd0, out_num},  32'd1);
    in_num = 16'd34; in_num2 = 16'd55; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("bp_no_push_when_full", {29'd0, level}, 32'd4);
    checkOutput("bp_out_still_held",    {16'd0, out_num}, 32'd1);
    out_ready = 1'b1;
    waitDrain(30);
    checkOutput("bp_drained_level", {29'd0, level}, 32'd0);
    checkOutput("bp_err", {31'd0, err}, 32'd0);

    // Modular wrap of the recurrence
    applyReset(2);
    rst = 1'b0;
    applyStimulus(16'd28657, 16'd46368);
    applyStimulus(16'd9489,  16'd55857);
    waitDrain(20);
    checkOutput("wrap_err", {31'd0, err}, 32'd0);

    // Recurrence checker: (2,4) breaks d == b + c
    applyReset(2);
    rst = 1'b0;
    applyStimulus(16'd1, 16'd1);
    checkOutput("chk_first_exempt", {31'd0, err}, 32'd0);
    applyStimulus(16'd2, 16'd4);
    checkOutput("chk_err_set", {31'd0, err}, {31'd0, CHECK_ERR});
    waitDrain(20);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("chk_err_held", {31'd0, err}, {31'd0, CHECK_ERR});
    applyReset(1);
    checkOutput("chk_err_cleared", {31'd0, err}, 32'd0);
    rst = 1'b0;

    // Reset in the middle of operation
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(bpVec[i].num, bpVec[i].num2);
    checkOutput("mid_level_before", {29'd0, level}, 32'd3);
    applyReset(1);
    rst = 1'b0;
    checkOutput("mid_level_after",     {29'd0, level},     32'd0);
    checkOutput("mid_out_valid_after", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    applyStimulus(16'd1, 16'd1);
    applyStimulus(16'd2, 16'd3);
    waitDrain(20);
    checkOutput("mid_new_pair_exempt", {31'd0, err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] global timeout");
  end

endmodule
